// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-colour stage: default timing,
// pattern-mode encodings, colour constants and the bar colour lookup.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_BOX   = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_e;

    // Direction of travel of the bouncing box along one axis
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    // 12-bit colours packed as {R[3:0], G[3:0], B[3:0]}
    localparam logic [11:0] WHITE   = 12'hFFF;
    localparam logic [11:0] BLACK   = 12'h000;
    localparam logic [11:0] RED     = 12'hF00;
    localparam logic [11:0] BG_BLUE = 12'h002;

    // Bar 0 is white, bar 7 is black; each RGB bit of (7 - idx) drives a full channel
    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        logic [2:0] c;
        c = 3'd7 - idx;
        return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position tracker. On each frame-boundary pulse the box moves
// one pixel per axis and reverses direction at the edges of the active area,
// so bx stays in 0..H_ACTIVE-BOX_SIZE and by in 0..V_ACTIVE-BOX_SIZE.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fb,
    output logic [9:0] bx,
    output logic [9:0] by
);

    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BOX_SIZE);

    // Direction state is kept as named registers so checkers can bind to dx/dy
    dir_e       dx, dy;
    dir_e       dx_nxt, dy_nxt;
    logic [9:0] bx_nxt, by_nxt;

    // Position and direction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bx <= 10'd0;
            by <= 10'd0;
            dx <= DIR_POS;
            dy <= DIR_POS;
        end else begin
            bx <= bx_nxt;
            by <= by_nxt;
            dx <= dx_nxt;
            dy <= dy_nxt;
        end
    end

    // Next position/direction: hold between frames, step or bounce on fb
    always_comb begin
        bx_nxt = bx;
        by_nxt = by;
        dx_nxt = dx;
        dy_nxt = dy;
        if (fb) begin
            if (dx == DIR_POS && bx == X_MAX) begin
                dx_nxt = DIR_NEG;
                bx_nxt = bx - 10'd1;
            end else if (dx == DIR_NEG && bx == 10'd0) begin
                dx_nxt = DIR_POS;
                bx_nxt = 10'd1;
            end else if (dx == DIR_POS) begin
                bx_nxt = bx + 10'd1;
            end else begin
                bx_nxt = bx - 10'd1;
            end

            if (dy == DIR_POS && by == Y_MAX) begin
                dy_nxt = DIR_NEG;
                by_nxt = by - 10'd1;
            end else if (dy == DIR_NEG && by == 10'd0) begin
                dy_nxt = DIR_POS;
                by_nxt = 10'd1;
            end else if (dy == DIR_POS) begin
                by_nxt = by + 10'd1;
            end else begin
                by_nxt = by - 10'd1;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage between the sync generator and the output colour
// register. Two pipeline stages: stage 1 registers position, syncs, mode and
// the colour-bar index; stage 2 selects the pattern colour and registers RGB
// together with the syncs, so every output lags its inputs by exactly 2 clk.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int BAR_W     = H_ACTIVE_DEF / 8,
    parameter int CHK_SHIFT = 5,
    parameter int BOX_SIZE  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic [7:0] frame_cnt
);

    localparam int BAR_PX_W = $clog2(BAR_W);

    logic [9:0]          hpos_s1, vpos_s1;
    logic                de_s1, hs_s1, vs_s1;
    logic [1:0]          mode_s1;
    logic [BAR_PX_W-1:0] bar_px;
    logic [2:0]          bar_idx;
    mode_e               mode_q;
    logic                fb;
    logic [9:0]          bx, by;
    logic [10:0]         bx_end, by_end;
    logic                in_box, blank;
    logic [11:0]         pix, rgb_q;
    logic                hs_s2, vs_s2;

    // Stage 1: capture inputs; the bar index is a counter that tracks hpos
    // (restarting at hpos==0) so no divide by BAR_W is needed. mode is
    // registered here so the frame boundary samples it alongside the position.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_s1 <= 10'd0;
            vpos_s1 <= 10'd0;
            de_s1   <= 1'b0;
            hs_s1   <= 1'b1;
            vs_s1   <= 1'b1;
            mode_s1 <= 2'd0;
            bar_px  <= '0;
            bar_idx <= 3'd0;
        end else begin
            hpos_s1 <= hpos;
            vpos_s1 <= vpos;
            de_s1   <= display_on;
            hs_s1   <= hsync_in;
            vs_s1   <= vsync_in;
            mode_s1 <= mode;
            if (hpos == 10'd0) begin
                bar_px  <= '0;
                bar_idx <= 3'd0;
            end else if (bar_px == BAR_PX_W'(BAR_W - 1)) begin
                bar_px <= '0;
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    // Frame boundary: first pixel of the first line after the active area,
    // taken from stage 1 so frame_cnt keeps the same 2 clk latency as RGB
    assign fb = (vpos_s1 == 10'(V_ACTIVE)) && (hpos_s1 == 10'd0);

    // Per-frame state: latch the pattern select and count completed frames
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_BARS;
            frame_cnt <= 8'd0;
        end else if (fb) begin
            mode_q    <= mode_e'(mode_s1);
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE)
    ) u_box (
        .clk   (clk),
        .reset (reset),
        .fb    (fb),
        .bx    (bx),
        .by    (by)
    );

    // Pattern colour mux; box bounds use 11 bits so bx+BOX_SIZE cannot wrap
    always_comb begin
        pix    = BLACK;
        bx_end = {1'b0, bx} + 11'(BOX_SIZE);
        by_end = {1'b0, by} + 11'(BOX_SIZE);
        in_box = (hpos_s1 >= bx) && ({1'b0, hpos_s1} < bx_end) &&
                 (vpos_s1 >= by) && ({1'b0, vpos_s1} < by_end);
        blank  = !de_s1 || (hpos_s1 >= 10'(H_ACTIVE)) || (vpos_s1 >= 10'(V_ACTIVE));
        if (!blank) begin
            case (mode_q)
                MODE_BARS:  pix = bar_colour(bar_idx);
                MODE_CHECK: pix = (hpos_s1[CHK_SHIFT] ^ vpos_s1[CHK_SHIFT]) ? WHITE : BLACK;
                MODE_BOX:   pix = in_box ? RED : BG_BLUE;
                MODE_GRAD:  pix = {hpos_s1[9:6], vpos_s1[8:5], hpos_s1[5:2]};
                default:    pix = BLACK;
            endcase
        end
    end

    // Stage 2: register colour and syncs together; syncs idle high in reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= BLACK;
            hs_s2 <= 1'b1;
            vs_s2 <= 1'b1;
        end else begin
            rgb_q <= pix;
            hs_s2 <= hs_s1;
            vs_s2 <= vs_s1;
        end
    end

    assign vga_r     = rgb_q[11:8];
    assign vga_g     = rgb_q[7:4];
    assign vga_b     = rgb_q[3:0];
    assign hsync_out = hs_s2;
    assign vsync_out = vs_s2;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: every driven pixel pushes its expected
// {RGB, hsync, vsync, frame_cnt} onto a queue, which is popped and compared
// two clocks later when the DUT presents that pixel.
module tb_vga_pattern_gen;

    logic       clk_25;
    logic       reset;
    logic [1:0] mode;
    logic       hsync_in, vsync_in, display_on;
    logic [9:0] hpos, vpos;
    logic       hsync_out, vsync_out;
    logic [3:0] vga_r, vga_g, vga_b;
    logic [7:0] frame_cnt;

    vga_pattern_gen dut (
        .clk        (clk_25),
        .reset      (reset),
        .mode       (mode),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .frame_cnt  (frame_cnt)
    );

    // Clock: 25 MHz
    initial clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    // Scoreboard and reference state
    int          checks = 0;
    int          errors = 0;
    logic [21:0] exp_q[$];
    int          tag_q[$];
    int          m_fc   = 0;   // expected frame counter
    int          m_n    = 0;   // frame boundaries since reset
    logic [1:0]  m_mode = 2'd0;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        de;
        logic [1:0]  m;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(int h, int v, logic de, logic [1:0] m, logic [11:0] rgb);
        vec_t r;
        r.h = 10'(h); r.v = 10'(v); r.de = de; r.m = m; r.rgb = rgb;
        return r;
    endfunction

    function automatic logic hs_of(int h);
        return !(h >= 656 && h < 752);
    endfunction

    function automatic logic vs_of(int v);
        return !(v == 490 || v == 491);
    endfunction

    // Box position after n boundaries: triangle wave 0..span..0
    function automatic int tri_wave(int n, int span);
        int p;
        p = n % (2 * span);
        return (p <= span) ? p : 2 * span - p;
    endfunction

    function automatic logic [11:0] model_pix(int h, int v, logic de, logic [1:0] md, int bx, int by);
        int idx, c;
        if (!de || h >= 640 || v >= 480) return 12'h000;
        case (md)
            2'd0: begin
                idx = h / 80;
                if (idx > 7) idx = 7;
                c = 7 - idx;
                return {((c & 4) != 0) ? 4'hF : 4'h0,
                        ((c & 2) != 0) ? 4'hF : 4'h0,
                        ((c & 1) != 0) ? 4'hF : 4'h0};
            end
            2'd1: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
            2'd2: return (h >= bx && h < bx + 32 && v >= by && v < by + 32) ? 12'hF00 : 12'h002;
            default: return {4'((h >> 6) & 15), 4'((v >> 5) & 15), 4'((h >> 2) & 15)};
        endcase
    endfunction

    task automatic check_out();
        logic [21:0] e, act;
        int t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        act = {vga_r, vga_g, vga_b, hsync_out, vsync_out, frame_cnt};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL pix h=%0d v=%0d got rgb/hs/vs/fc=%h required %h", t / 1024, t % 1024, act, e);
        end
    endtask

    // Driver: apply one pixel, push its expectation, advance one clock
    task automatic drive(int h, int v, logic de, logic [1:0] m,
                         logic use_tbl = 1'b0, logic [11:0] tbl_rgb = 12'h000);
        logic [11:0] rgb;
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = de;
        mode       = m;
        hsync_in   = hs_of(h);
        vsync_in   = vs_of(v);
        rgb = use_tbl ? tbl_rgb
                      : model_pix(h, v, de, m_mode, tri_wave(m_n, 608), tri_wave(m_n, 448));
        if (h == 0 && v == 480) begin
            m_mode = m;
            m_fc   = (m_fc + 1) % 256;
            m_n++;
        end
        exp_q.push_back({rgb, hs_of(h), vs_of(v), 8'(m_fc)});
        tag_q.push_back(h * 1024 + v);
        @(posedge clk_25);
        #1;
        if (exp_q.size() >= 2) check_out();
    endtask

    // Reset for n clocks, check reset values, then release
    task automatic do_reset(int n);
        logic [21:0] act;
        reset = 1'b1;
        repeat (n) @(posedge clk_25);
        #1;
        act = {vga_r, vga_g, vga_b, hsync_out, vsync_out, frame_cnt};
        checks++;
        if (act !== {12'h000, 1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reset_out got %h required %h", act, {12'h000, 1'b1, 1'b1, 8'd0});
        end
        checks++;
        if ({dut.bx, dut.by, 2'(dut.mode_q)} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state got bx=%0d by=%0d mode_q=%0d required 0 0 0",
                     dut.bx, dut.by, dut.mode_q);
        end
        exp_q.delete();
        tag_q.delete();
        m_fc   = 0;
        m_n    = 0;
        m_mode = 2'd0;
        // First output after release still reflects the cleared stage 1
        exp_q.push_back({12'h000, 1'b1, 1'b1, 8'd0});
        tag_q.push_back(0);
        reset = 1'b0;
    endtask

    task automatic sweep_line(int v, logic [1:0] m);
        for (int h = 0; h < 800; h++) drive(h, v, (h < 640), m);
    endtask

    task automatic probe_box();
        int bx, by;
        bx = tri_wave(m_n, 608);
        by = tri_wave(m_n, 448);
        drive(bx, by, 1'b1, 2'd2);
        drive(bx + 31, by + 31, 1'b1, 2'd2);
        if (bx + 32 < 640) drive(bx + 32, by, 1'b1, 2'd2);
        if (bx > 0) drive(bx - 1, by, 1'b1, 2'd2);
        if (by + 32 < 480) drive(bx, by + 32, 1'b1, 2'd2);
        if (by > 0) drive(bx, by - 1, 1'b1, 2'd2);
    endtask

    initial begin
        // Mode 1 checkerboard, mode 3 gradient, blanking, mid-frame mode change
        tbl[0]  = mk(0,   480, 1'b1, 2'd1, 12'h000);
        tbl[1]  = mk(0,   0,   1'b1, 2'd1, 12'h000);
        tbl[2]  = mk(32,  0,   1'b1, 2'd1, 12'hFFF);
        tbl[3]  = mk(32,  32,  1'b1, 2'd1, 12'h000);
        tbl[4]  = mk(0,   32,  1'b1, 2'd1, 12'hFFF);
        tbl[5]  = mk(64,  0,   1'b1, 2'd1, 12'h000);
        tbl[6]  = mk(96,  64,  1'b1, 2'd1, 12'hFFF);
        tbl[7]  = mk(32,  0,   1'b0, 2'd1, 12'h000);
        tbl[8]  = mk(640, 0,   1'b1, 2'd1, 12'h000);
        tbl[9]  = mk(639, 0,   1'b1, 2'd1, 12'hFFF);
        tbl[10] = mk(0,   480, 1'b1, 2'd3, 12'h000);
        tbl[11] = mk(100, 37,  1'b1, 2'd3, 12'h119);
        tbl[12] = mk(620, 416, 1'b1, 2'd3, 12'h9DB);
        tbl[13] = mk(639, 479, 1'b1, 2'd3, 12'h9EF);
        tbl[14] = mk(0,   479, 1'b1, 2'd3, 12'h0E0);
        tbl[15] = mk(100, 37,  1'b0, 2'd3, 12'h000);
        tbl[16] = mk(100, 480, 1'b1, 2'd3, 12'h000);
        tbl[17] = mk(5,   0,   1'b1, 2'd0, 12'h001);

        // Power-up reset with live-looking inputs
        mode = 2'd0; hpos = 10'd0; vpos = 10'd0; display_on = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0; reset = 1'b1;
        do_reset(3);

        // Colour bars across a full line, including the hsync pulse
        sweep_line(0, 2'd0);

        // Table vectors
        for (int i = 0; i < 18; i++)
            drive(int'(tbl[i].h), int'(tbl[i].v), tbl[i].de, tbl[i].m, 1'b1, tbl[i].rgb);

        // Mode change mid-frame: bars continue, box starts after the boundary
        do_reset(1);
        sweep_line(100, 2'd2);
        drive(0, 480, 1'b1, 2'd2);
        probe_box();

        // Bounce run: edge reversals and frame_cnt wrap
        while (m_n < 1220) begin
            drive(0, 480, 1'b1, 2'd2);
            drive(1, 490, 1'b0, 2'd2);
            if (m_n inside {2, 255, 256, 257, 447, 448, 449, 607, 608, 609, 610,
                            895, 896, 897, 1215, 1216, 1217})
                probe_box();
            if (m_n % 50 == 0)
                drive(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1, 2'd2);
        end

        // Reset in the middle of a frame, then mode must be back to bars
        drive(300, 200, 1'b1, 2'd2);
        drive(301, 200, 1'b1, 2'd2);
        hpos = 10'd302; hsync_in = 1'b0; vsync_in = 1'b0;
        do_reset(1);
        sweep_line(0, 2'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
